// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and defaults for the data-memory arbiter
//
// Purpose: owner encoding used by the arbiter state register and the
//          next-owner picker, default bus widths, owner-to-grant decode.
// Contents: owner_t, DEF_AWIDTH, DEF_DWIDTH, owner_gnt()
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_R0   = 2'd1,
    OWN_R1   = 2'd2
  } owner_t;

  localparam int DEF_AWIDTH = 7;
  localparam int DEF_DWIDTH = 32;

  // Owner register is the grant; this is its one-hot-or-zero view.
  function automatic logic [1:0] owner_gnt(input owner_t o);
    case (o)
      OWN_R0:  return 2'b01;
      OWN_R1:  return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester and memory pins of the data-memory arbiter
//
// Purpose: bundles both requester ports and the memory-side pins.
// Ports (signals):
//   req[1:0], we[1:0], addr0/1, wdata0/1  requester transaction inputs
//   gnt[1:0], rvalid[1:0], rdata, busy     arbiter responses
//   mem_addr, mem_wdata, mem_we            arbiter drives memory
//   mem_rdata                              combinational memory read data
// Modports: slave = arbiter view, master = requesters plus memory view.
interface dmem_arbiter_if #(
  parameter int AWIDTH = dmem_arb_pkg::DEF_AWIDTH,
  parameter int DWIDTH = dmem_arb_pkg::DEF_DWIDTH
);

  logic [1:0]        req;
  logic [1:0]        we;
  logic [AWIDTH-1:0] addr0;
  logic [AWIDTH-1:0] addr1;
  logic [DWIDTH-1:0] wdata0;
  logic [DWIDTH-1:0] wdata1;
  logic [1:0]        gnt;
  logic [1:0]        rvalid;
  logic [DWIDTH-1:0] rdata;
  logic              busy;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_wdata;
  logic              mem_we;
  logic [DWIDTH-1:0] mem_rdata;

  modport slave (
    input  req, we, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt, rvalid, rdata, busy, mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req, we, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt, rvalid, rdata, busy, mem_addr, mem_wdata, mem_we
  );

endinterface

// File: rtl/dmem_arb_pick.sv
// rtl/dmem_arb_pick.sv - next-owner and hold-count decision for the arbiter
//
// Purpose: purely combinational round-robin pick with bounded burst hold.
// Ports:
//   i_req[1:0]  current requests
//   i_owner     registered owner (current grant)
//   i_last      most recent owner, 1 = R1
//   i_hold      consecutive grants given to i_owner
//   o_owner     owner for the next cycle
//   o_hold      hold count for the next cycle
module dmem_arb_pick
  import dmem_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int HW       = $clog2(MAX_HOLD + 1)
) (
  input  logic [1:0]    i_req,
  input  owner_t        i_owner,
  input  logic          i_last,
  input  logic [HW-1:0] i_hold,
  output owner_t        o_owner,
  output logic [HW-1:0] o_hold
);

  logic w_hold_full;

  assign w_hold_full = (i_hold >= HW'(MAX_HOLD));

  always_comb begin
    o_owner = OWN_NONE;
    o_hold  = '0;

    case (i_owner)
      OWN_NONE: begin
        case (i_req)
          2'b01:   o_owner = OWN_R0;
          2'b10:   o_owner = OWN_R1;
          // Tie from idle goes to whoever did not own last.
          2'b11:   o_owner = i_last ? OWN_R0 : OWN_R1;
          default: o_owner = OWN_NONE;
        endcase
      end
      OWN_R0: begin
        if (i_req[0])
          o_owner = (i_req[1] && w_hold_full) ? OWN_R1 : OWN_R0;
        else
          o_owner = i_req[1] ? OWN_R1 : OWN_NONE;
      end
      OWN_R1: begin
        if (i_req[1])
          o_owner = (i_req[0] && w_hold_full) ? OWN_R0 : OWN_R1;
        else
          o_owner = i_req[0] ? OWN_R0 : OWN_NONE;
      end
      default: o_owner = OWN_NONE;
    endcase

    // Count restarts on every change of hands and saturates while retained,
    // so a long solo burst yields at once when the other side shows up.
    if (o_owner == OWN_NONE)
      o_hold = '0;
    else if (o_owner != i_owner)
      o_hold = HW'(1);
    else if (!w_hold_full)
      o_hold = i_hold + HW'(1);
    else
      o_hold = i_hold;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester round-robin arbiter for the data memory
//
// Purpose: shares a single-port data memory between the load/store path (R0)
//          and the DMA/debug port (R1); drives the memory pins from the
//          registered grant and returns registered read data.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  dmem_arbiter_if.slave: requester inputs, gnt/rvalid/rdata/busy,
//        memory address/write-data/write-enable, memory read data
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AWIDTH   = DEF_AWIDTH,
  parameter int DWIDTH   = DEF_DWIDTH,
  parameter int MAX_HOLD = 4
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  localparam int HW = $clog2(MAX_HOLD + 1);

  owner_t            r_owner;
  logic              r_last;
  logic [HW-1:0]     r_hold;
  logic [1:0]        r_rvalid;
  logic [DWIDTH-1:0] r_rdata;

  owner_t            w_nxt_owner;
  logic [HW-1:0]     w_nxt_hold;
  logic [1:0]        w_gnt;
  logic [1:0]        w_rd;
  logic [AWIDTH-1:0] w_mem_addr;
  logic [DWIDTH-1:0] w_mem_wdata;
  logic              w_mem_we;

  dmem_arb_pick #(
    .MAX_HOLD (MAX_HOLD),
    .HW       (HW)
  ) u_pick (
    .i_req   (bus.req),
    .i_owner (r_owner),
    .i_last  (r_last),
    .i_hold  (r_hold),
    .o_owner (w_nxt_owner),
    .o_hold  (w_nxt_hold)
  );

  assign w_gnt = owner_gnt(r_owner);

  // Memory pins depend only on the registered grant and the granted side's
  // inputs. A grant whose request has been withdrawn is spent with no access.
  always_comb begin
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    w_mem_we    = 1'b0;
    w_rd        = 2'b00;
    if (w_gnt[0]) begin
      w_mem_addr  = bus.addr0;
      w_mem_wdata = bus.wdata0;
      w_mem_we    = bus.we[0] & bus.req[0];
      w_rd[0]     = bus.req[0] & ~bus.we[0];
    end else if (w_gnt[1]) begin
      w_mem_addr  = bus.addr1;
      w_mem_wdata = bus.wdata1;
      w_mem_we    = bus.we[1] & bus.req[1];
      w_rd[1]     = bus.req[1] & ~bus.we[1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner  <= OWN_NONE;
      r_last   <= 1'b1;
      r_hold   <= '0;
      r_rvalid <= 2'b00;
      r_rdata  <= '0;
    end else begin
      r_owner  <= w_nxt_owner;
      r_hold   <= w_nxt_hold;
      if (w_nxt_owner != OWN_NONE)
        r_last <= (w_nxt_owner == OWN_R1);
      r_rvalid <= w_rd;
      if (|w_rd)
        r_rdata <= bus.mem_rdata;
    end
  end

  assign bus.gnt       = w_gnt;
  assign bus.busy      = |w_gnt;
  assign bus.rvalid    = r_rvalid;
  assign bus.rdata     = r_rdata;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;
  assign bus.mem_we    = w_mem_we;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic do_init = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.AWIDTH(7), .DWIDTH(32)) bus ();

  dmem_arbiter #(.AWIDTH(7), .DWIDTH(32), .MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [31:0] mem [128];

  function automatic logic [31:0] init_word(input int j);
    if (j == 3) return 32'h11;
    if (j == 4) return 32'h22;
    return 32'hC000_0000 | 32'(j);
  endfunction

  always @(posedge clk) begin
    if (do_init) begin
      for (int j = 0; j < 128; j++) mem[j] <= init_word(j);
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  assign bus.mem_rdata = mem[bus.mem_addr];

  typedef struct packed {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [6:0]  a0;
    logic [6:0]  a1;
    logic [31:0] wd0;
    logic [31:0] wd1;
    logic [1:0]  gnt;
    logic        mwe;
    logic [6:0]  maddr;
    logic [31:0] mwdata;
    logic [1:0]  rv;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] req, input logic [1:0] we,
                       input logic [6:0] a0, input logic [6:0] a1,
                       input logic [31:0] wd0, input logic [31:0] wd1);
    bus.req = req;
    bus.we = we;
    bus.addr0 = a0;
    bus.addr1 = a1;
    bus.wdata0 = wd0;
    bus.wdata1 = wd1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            req    we     a0  a1  wd0    wd1  | gnt   mwe maddr mwdata rv     rd
    tbl[0]  = '{2'b11, 2'b00, 7'd3, 7'd4, 32'h0,  32'h0, 2'b00, 1'b0, 7'd0, 32'h0,  2'b00, 32'h0};
    tbl[1]  = '{2'b11, 2'b00, 7'd3, 7'd4, 32'h0,  32'h0, 2'b01, 1'b0, 7'd3, 32'h0,  2'b00, 32'h0};
    tbl[2]  = '{2'b10, 2'b00, 7'd3, 7'd4, 32'h0,  32'h0, 2'b01, 1'b0, 7'd3, 32'h0,  2'b01, 32'h11};
    tbl[3]  = '{2'b10, 2'b00, 7'd3, 7'd4, 32'h0,  32'h0, 2'b10, 1'b0, 7'd4, 32'h0,  2'b00, 32'h11};
    tbl[4]  = '{2'b00, 2'b00, 7'd3, 7'd4, 32'h0,  32'h0, 2'b10, 1'b0, 7'd4, 32'h0,  2'b10, 32'h22};
    tbl[5]  = '{2'b00, 2'b00, 7'd0, 7'd0, 32'h0,  32'h0, 2'b00, 1'b0, 7'd0, 32'h0,  2'b00, 32'h22};
    tbl[6]  = '{2'b01, 2'b01, 7'd5, 7'd0, 32'hA5, 32'h0, 2'b00, 1'b0, 7'd0, 32'h0,  2'b00, 32'h22};
    tbl[7]  = '{2'b01, 2'b01, 7'd5, 7'd0, 32'hA5, 32'h0, 2'b01, 1'b1, 7'd5, 32'hA5, 2'b00, 32'h22};
    tbl[8]  = '{2'b00, 2'b01, 7'd5, 7'd0, 32'h5A, 32'h0, 2'b01, 1'b0, 7'd5, 32'h5A, 2'b00, 32'h22};
    tbl[9]  = '{2'b00, 2'b00, 7'd0, 7'd0, 32'h0,  32'h0, 2'b00, 1'b0, 7'd0, 32'h0,  2'b00, 32'h22};
    tbl[10] = '{2'b01, 2'b00, 7'd5, 7'd0, 32'h0,  32'h0, 2'b00, 1'b0, 7'd0, 32'h0,  2'b00, 32'h22};
    tbl[11] = '{2'b11, 2'b00, 7'd5, 7'd3, 32'h0,  32'h0, 2'b01, 1'b0, 7'd5, 32'h0,  2'b00, 32'h22};
    tbl[12] = '{2'b11, 2'b00, 7'd5, 7'd3, 32'h0,  32'h0, 2'b01, 1'b0, 7'd5, 32'h0,  2'b01, 32'hA5};
    tbl[13] = '{2'b11, 2'b00, 7'd5, 7'd3, 32'h0,  32'h0, 2'b01, 1'b0, 7'd5, 32'h0,  2'b01, 32'hA5};
    tbl[14] = '{2'b11, 2'b00, 7'd5, 7'd3, 32'h0,  32'h0, 2'b01, 1'b0, 7'd5, 32'h0,  2'b01, 32'hA5};
    tbl[15] = '{2'b11, 2'b00, 7'd5, 7'd3, 32'h0,  32'h0, 2'b10, 1'b0, 7'd3, 32'h0,  2'b01, 32'hA5};
    tbl[16] = '{2'b01, 2'b00, 7'd5, 7'd3, 32'h0,  32'h0, 2'b10, 1'b0, 7'd3, 32'h0,  2'b10, 32'h11};
    tbl[17] = '{2'b01, 2'b00, 7'd5, 7'd3, 32'h0,  32'h0, 2'b01, 1'b0, 7'd5, 32'h0,  2'b00, 32'h11};

    drive(2'b00, 2'b00, 7'd0, 7'd0, 32'h0, 32'h0);

    // Reset state, memory preloaded while reset is held.
    repeat (3) @(negedge clk);
    do_init = 1'b0;
    #1;
    chk("rst_gnt",    32'(bus.gnt),       32'h0);
    chk("rst_rvalid", 32'(bus.rvalid),    32'h0);
    chk("rst_rdata",  bus.rdata,          32'h0);
    chk("rst_busy",   32'(bus.busy),      32'h0);
    chk("rst_mem_we", 32'(bus.mem_we),    32'h0);
    chk("rst_maddr",  32'(bus.mem_addr),  32'h0);
    chk("rst_mwdata", bus.mem_wdata,      32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Table: tie from reset, back-to-back switch, write, suppressed write,
    // burst hold limit, owner hand-back.
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(tbl[i].req, tbl[i].we, tbl[i].a0, tbl[i].a1, tbl[i].wd0, tbl[i].wd1);
      #1;
      chk($sformatf("v%0d_gnt", i),    32'(bus.gnt),      32'(tbl[i].gnt));
      chk($sformatf("v%0d_busy", i),   32'(bus.busy),     32'(|tbl[i].gnt));
      chk($sformatf("v%0d_mwe", i),    32'(bus.mem_we),   32'(tbl[i].mwe));
      chk($sformatf("v%0d_maddr", i),  32'(bus.mem_addr), 32'(tbl[i].maddr));
      chk($sformatf("v%0d_mwdata", i), bus.mem_wdata,     tbl[i].mwdata);
      chk($sformatf("v%0d_rvalid", i), 32'(bus.rvalid),   32'(tbl[i].rv));
      chk($sformatf("v%0d_rdata", i),  bus.rdata,         tbl[i].rd);
    end

    // R0 alone for 11 reads: grant held, hold count saturates.
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      drive(2'b01, 2'b00, 7'(10 + k), 7'd0, 32'h0, 32'h0);
      #1;
      chk($sformatf("sat%0d_gnt", k),    32'(bus.gnt),    32'h1);
      chk($sformatf("sat%0d_rvalid", k), 32'(bus.rvalid), 32'h1);
      chk($sformatf("sat%0d_rdata", k),  bus.rdata,
          (k == 0) ? 32'hA5 : (32'hC000_0000 | 32'(10 + k - 1)));
    end

    // R1 arrives while R0's count is saturated: yields after one more grant.
    @(negedge clk);
    drive(2'b11, 2'b00, 7'd21, 7'd4, 32'h0, 32'h0);
    #1;
    chk("join_gnt",   32'(bus.gnt),    32'h1);
    chk("join_rdata", bus.rdata,       32'hC000_0014);

    // R1 write granted with no bubble, then reset lands mid-grant.
    @(negedge clk);
    drive(2'b10, 2'b10, 7'd0, 7'd7, 32'h0, 32'hDEAD_BEEF);
    #1;
    chk("wr1_gnt",    32'(bus.gnt),      32'h2);
    chk("wr1_mwe",    32'(bus.mem_we),   32'h1);
    chk("wr1_maddr",  32'(bus.mem_addr), 32'h7);
    chk("wr1_rvalid", 32'(bus.rvalid),   32'h1);
    chk("wr1_rdata",  bus.rdata,         32'hC000_0015);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_gnt",    32'(bus.gnt),    32'h0);
    chk("arst_mwe",    32'(bus.mem_we), 32'h0);
    chk("arst_rvalid", 32'(bus.rvalid), 32'h0);
    chk("arst_busy",   32'(bus.busy),   32'h0);
    chk("arst_rdata",  bus.rdata,       32'h0);

    @(negedge clk);
    rst = 1'b1;
    drive(2'b11, 2'b00, 7'd3, 7'd4, 32'h0, 32'h0);
    #1;
    chk("mem7_kept",  mem[7],         32'hC000_0007);
    chk("post_gnt0",  32'(bus.gnt),   32'h0);
    @(negedge clk);
    #1;
    chk("post_tie",   32'(bus.gnt),   32'h1);
    chk("post_maddr", 32'(bus.mem_addr), 32'h3);
    @(negedge clk);
    #1;
    chk("post_rvalid", 32'(bus.rvalid), 32'h1);
    chk("post_rdata",  bus.rdata,       32'h11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
